// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, register ids, status codes
// and destination-register helpers used by the writeback stage.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    // E-port destination; rrmovq is cmov with ifun 0 and always moves
    function automatic logic [3:0] dst_e_of(
        input logic [3:0] icode,
        input logic [3:0] ifun,
        input logic       cnd,
        input logic [3:0] rb
    );
        logic [3:0] d;
        d = RNONE;
        case (icode)
            IOPQ, IIRMOVQ: d = rb;
            IRRMOVQ: d = (ifun == 4'h0 || cnd) ? rb : RNONE;
            IPUSHQ, IPOPQ, ICALL, IRET: d = RRSP;
            default: d = RNONE;
        endcase
        return d;
    endfunction

    // M-port destination: loads from memory into rA
    function automatic logic [3:0] dst_m_of(
        input logic [3:0] icode,
        input logic [3:0] ra
    );
        return (icode == IMRMOVQ || icode == IPOPQ) ? ra : RNONE;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: two async read ports, two sync write ports.
// WB_BYPASS_EN: reads forward the value being committed this cycle.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int NREGS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] rd_a,
    output logic [63:0] rd_b
);

    localparam logic [3:0] NR = NREGS[3:0];

    logic [63:0] regs [NREGS];

    function automatic logic [63:0] read_port(input logic [3:0] src);
`ifdef WB_BYPASS_EN
        if (we && src != RNONE && src == dst_m) begin
            return val_m;
        end
        if (we && src != RNONE && src == dst_e) begin
            return val_e;
        end
`endif
        if (src == RNONE || src >= NR) begin
            return 64'd0;
        end
        return regs[src];
    endfunction

    // Read ports, optionally write-through
    always_comb begin
        rd_a = read_port(src_a);
        rd_b = read_port(src_b);
    end

    // Commit writes; M port written last so it wins on a shared destination
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 64'd0;
            end
        end else if (we) begin
            if (dst_e != RNONE && dst_e < NR) begin
                regs[dst_e] <= val_e;
            end
            if (dst_m != RNONE && dst_m < NR) begin
                regs[dst_m] <= val_m;
            end
        end
    end

endmodule

// File: rtl/writeback_pc_update.sv
// Y86-64 writeback / PC update stage: register commit, next PC, sticky
// status and retire counter. Optional macro WB_BYPASS_EN (read bypass).
module writeback_pc_update
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          NREGS    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic        cnd,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        mem_err,
    input  logic        instruct_err,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] PC,
    output logic [2:0]  stat,
    output logic [63:0] retired
);

    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] pc_q;
    logic [63:0] pc_nx;
    logic [63:0] retired_q;
    stat_t       stat_q;
    stat_t       stat_nx;
    logic        commit;

    // Decode destinations, new status and commit enable
    always_comb begin
        dst_e = dst_e_of(icode, ifun, cnd, rb);
        dst_m = dst_m_of(icode, ra);
        if (instruct_err) begin
            stat_nx = STAT_INS;
        end else if (mem_err) begin
            stat_nx = STAT_ADR;
        end else if (icode == IHALT) begin
            stat_nx = STAT_HLT;
        end else begin
            stat_nx = STAT_AOK;
        end
        commit = (stat_q == STAT_AOK) && !instruct_err && !mem_err;
    end

    // Next PC selection
    always_comb begin
        pc_nx = valP;
        case (icode)
            ICALL: pc_nx = valC;
            IJXX:  pc_nx = cnd ? valC : valP;
            IRET:  pc_nx = valM;
            IHALT: pc_nx = pc_q;
            default: pc_nx = valP;
        endcase
    end

    // PC, status and retire counter; everything freezes once stat leaves AOK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            stat_q    <= STAT_AOK;
            retired_q <= 64'd0;
        end else if (stat_q == STAT_AOK) begin
            stat_q <= stat_nx;
            if (commit) begin
                pc_q      <= pc_nx;
                retired_q <= retired_q + 64'd1;
            end
        end
    end

    y86_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (commit),
        .dst_e (dst_e),
        .val_e (valE),
        .dst_m (dst_m),
        .val_m (valM),
        .src_a (srcA),
        .src_b (srcB),
        .rd_a  (valA),
        .rd_b  (valB)
    );

    assign PC      = pc_q;
    assign stat    = stat_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_writeback_pc_update.sv
// Scoreboard bench for writeback_pc_update: directed cases then random
// instruction streams checked against an architectural reference model.
module tb_writeback_pc_update;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  icode = 4'h1;
    logic [3:0]  ifun = 4'h0;
    logic        cnd = 1'b0;
    logic [3:0]  ra = 4'hF;
    logic [3:0]  rb = 4'hF;
    logic [63:0] valC = '0;
    logic [63:0] valP = '0;
    logic [63:0] valE = '0;
    logic [63:0] valM = '0;
    logic        mem_err = 1'b0;
    logic        instruct_err = 1'b0;
    logic [3:0]  srcA = 4'hF;
    logic [3:0]  srcB = 4'hF;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] PC;
    logic [2:0]  stat;
    logic [63:0] retired;

    writeback_pc_update dut (
        .clk          (clk),
        .rst          (rst),
        .icode        (icode),
        .ifun         (ifun),
        .cnd          (cnd),
        .ra           (ra),
        .rb           (rb),
        .valC         (valC),
        .valP         (valP),
        .valE         (valE),
        .valM         (valM),
        .mem_err      (mem_err),
        .instruct_err (instruct_err),
        .srcA         (srcA),
        .srcB         (srcB),
        .valA         (valA),
        .valB         (valB),
        .PC           (PC),
        .stat         (stat),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [2:0]  st;
        logic [63:0] ret;
        logic [63:0] va;
        logic [63:0] vb;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // architectural reference state
    logic [63:0] mr [16];
    logic [63:0] mpc;
    int          mstat;
    logic [63:0] mret;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mr[i] = 64'd0;
        mpc = 64'd0;
        mstat = 1;
        mret = 64'd0;
    endtask

    // apply one instruction to the architectural model
    task automatic model_step();
        int ns;
        int de;
        int dm;
        if (mstat != 1) return;
        if (instruct_err) ns = 4;
        else if (mem_err) ns = 3;
        else if (icode == 0) ns = 2;
        else ns = 1;
        if (ns <= 2) begin
            de = 15;
            dm = 15;
            if (icode == 6 || icode == 3) de = rb;
            if (icode == 2 && (ifun == 0 || cnd)) de = rb;
            if (icode >= 8 && icode <= 11) de = 4;
            if (icode == 5 || icode == 11) dm = ra;
            if (de != 15) mr[de] = valE;
            if (dm != 15) mr[dm] = valM;
            if (icode == 8) mpc = valC;
            else if (icode == 7 && cnd) mpc = valC;
            else if (icode == 9) mpc = valM;
            else if (icode != 0) mpc = valP;
            mret = mret + 64'd1;
        end
        mstat = ns;
    endtask

    // drive one instruction (at a negedge) and record its expected result
    task automatic issue(
        input logic [3:0] ic, input logic [3:0] fn, input logic c,
        input logic [3:0] a, input logic [3:0] b,
        input logic [63:0] vc, input logic [63:0] vp,
        input logic [63:0] ve, input logic [63:0] vm,
        input logic me, input logic ie,
        input logic [3:0] sa, input logic [3:0] sb
    );
        exp_t e;
        icode = ic; ifun = fn; cnd = c; ra = a; rb = b;
        valC = vc; valP = vp; valE = ve; valM = vm;
        mem_err = me; instruct_err = ie; srcA = sa; srcB = sb;
        model_step();
        e.pc = mpc;
        e.st = mstat[2:0];
        e.ret = mret;
        e.va = mr[sa];
        e.vb = mr[sb];
        q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_pc", PC, mpc);
        chk("rst_stat", {61'd0, stat}, 64'd1);
        chk("rst_retired", retired, 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // monitor: compare DUT state after each clock edge against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", PC, e.pc);
                chk("stat", {61'd0, stat}, {61'd0, e.st});
                chk("retired", retired, e.ret);
                chk("valA", valA, e.va);
                chk("valB", valB, e.vb);
            end
        end
    end

    initial begin
        logic [3:0] ic;
        int n;
        model_reset();
        @(negedge clk);
        do_reset();

        // irmovq $0x1234, %rbx
        issue(4'h3, 4'h0, 1'b0, 4'hF, 4'h3, 64'h1234, 64'h4A,
              64'h1234, 64'h0, 1'b0, 1'b0, 4'h3, 4'h0);
        @(negedge clk);
        // same-cycle read of a register being committed
        issue(4'h3, 4'h0, 1'b0, 4'hF, 4'h3, 64'h55, 64'h54,
              64'h55, 64'h0, 1'b0, 1'b0, 4'h3, 4'h4);
        #1;
`ifdef WB_BYPASS_EN
        chk("bypass_valA", valA, 64'h55);
`else
        chk("bypass_valA", valA, 64'h1234);
`endif
        @(negedge clk);
        // popq %rsp: M port wins
        issue(4'hB, 4'h0, 1'b0, 4'h4, 4'hF, 64'h0, 64'h56,
              64'h108, 64'hDEAD, 1'b0, 1'b0, 4'h4, 4'h3);
        @(negedge clk);
        // call
        issue(4'h8, 4'h0, 1'b0, 4'hF, 4'hF, 64'h200, 64'h5F,
              64'h100, 64'h0, 1'b0, 1'b0, 4'h4, 4'h0);
        @(negedge clk);
        // cmovle not taken
        issue(4'h2, 4'h1, 1'b0, 4'h1, 4'h5, 64'h0, 64'h202,
              64'h7, 64'h0, 1'b0, 1'b0, 4'h5, 4'h1);
        @(negedge clk);
        // jne taken then not taken
        issue(4'h7, 4'h4, 1'b1, 4'hF, 4'hF, 64'h80, 64'h20B,
              64'h0, 64'h0, 1'b0, 1'b0, 4'h5, 4'hF);
        @(negedge clk);
        issue(4'h7, 4'h4, 1'b0, 4'hF, 4'hF, 64'h300, 64'h89,
              64'h0, 64'h0, 1'b0, 1'b0, 4'h3, 4'h4);
        @(negedge clk);
        // ret
        issue(4'h9, 4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h8A,
              64'h110, 64'h440, 1'b0, 1'b0, 4'h4, 4'h0);
        @(negedge clk);
        // mrmovq with address fault, then ignored AOK traffic
        issue(4'h5, 4'h0, 1'b0, 4'h6, 4'h2, 64'h8, 64'h44A,
              64'hBAD, 64'h77, 1'b1, 1'b0, 4'h6, 4'h4);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            issue(4'h3, 4'h0, 1'b0, 4'hF, 4'h6, 64'h9, 64'h99,
                  64'h9, 64'h0, 1'b0, 1'b0, 4'h6, 4'h3);
            @(negedge clk);
        end
        do_reset();

        // reset asserted mid-cycle while an instruction is presented
        issue(4'h3, 4'h0, 1'b0, 4'hF, 4'h3, 64'h5, 64'h10,
              64'h5, 64'h0, 1'b0, 1'b0, 4'h3, 4'h3);
        @(negedge clk);
        icode = 4'h3; rb = 4'h7; valE = 64'h66; valP = 64'h20;
        srcA = 4'h3;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_pc", PC, 64'd0);
        chk("midrst_stat", {61'd0, stat}, 64'd1);
        chk("midrst_retired", retired, 64'd0);
        chk("midrst_valA", valA, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // halt then frozen
        issue(4'h3, 4'h0, 1'b0, 4'hF, 4'h2, 64'h0, 64'h30,
              64'h42, 64'h0, 1'b0, 1'b0, 4'h2, 4'hF);
        @(negedge clk);
        issue(4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h31,
              64'h0, 64'h0, 1'b0, 1'b0, 4'h2, 4'h4);
        @(negedge clk);
        issue(4'h3, 4'h0, 1'b0, 4'hF, 4'h2, 64'h0, 64'h40,
              64'h1, 64'h0, 1'b0, 1'b1, 4'h2, 4'h4);
        @(negedge clk);
        do_reset();

        // random instruction streams
        for (int ep = 0; ep < 30; ep++) begin
            n = $urandom_range(5, 25);
            for (int k = 0; k < n; k++) begin
                ic = 4'($urandom_range(0, 11));
                if (ic == 4'h0 && ($urandom % 4) != 0) ic = 4'h1;
                issue(ic, 4'($urandom_range(0, 6)), 1'($urandom),
                      4'($urandom), 4'($urandom),
                      {$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom}, {$urandom, $urandom},
                      ($urandom % 40) == 0, ($urandom % 50) == 0,
                      4'($urandom), 4'($urandom));
                @(negedge clk);
            end
            do_reset();
        end

        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
